regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 16x32 register file. It owns the file's single write port (write enable, destination, write data, context flag) and shares it between two requesters: the ALU result path and the memory-load return path. Each requester has its own small FIFO. A fixed priority with a starvation guard picks one write per cycle. Writes to the hard-wired zero register R14 are discarded, and a hazard port lets issue logic stall on queued destinations.

## Interface
Parameters:
- DATA_W, 32, write-data width
- DEPTH, 2, entries per requester FIFO (power of two, >= 2)
- STARVE_MAX, 3, consecutive ALU losses before ALU is forced to win

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU FIFO can accept this cycle
- alu_rd  in  4  ALU destination register
- alu_data  in  DATA_W  ALU write data
- alu_ucode  in  1  ALU target context (1 = microcode file)
- mem_valid / mem_ready / mem_rd / mem_data / mem_ucode: same as ALU set, for the load path
- rf_write  out  1  write enable to the register file
- rf_rd  out  4  write destination
- rf_data  out  DATA_W  write data
- rf_ucode  out  1  context select for the write
- pending  out  1  at least one entry queued in either FIFO
- q_rd  in  4  hazard query register
- q_ucode  in  1  hazard query context
- q_hit  out  1  some queued entry matches (q_rd, q_ucode)
- drop_cnt  out  8  saturating count of discarded R14 writes

## Operation
- Handshake: a transfer occurs on a rising edge with X_valid && X_ready. X_ready = !full(X). A full FIFO does not accept a push, even in a cycle where it pops.
- Upstream holds rd/data/ucode stable while valid && !ready.
- R14 filter: an accepted request with rd == 14 is not enqueued. drop_cnt increments, saturating at 255. If both requesters push R14 in the same cycle, drop_cnt increases by 2, still saturating.
- Each FIFO keeps {rd, data, ucode} in strict arrival order.
- Arbitration is combinational from the FIFO heads:
  - Neither FIFO has entries: rf_write=0. rf_rd, rf_data and rf_ucode read 0.
  - Only one FIFO has entries: that FIFO's head is selected.
  - Both have entries: mem wins, unless starve_cnt == STARVE_MAX, in which case alu wins.
- Selected head drives rf_rd, rf_data and rf_ucode, with rf_write=1. That head is popped on the same rising edge the register file commits it.
- starve_cnt:
  - increments when alu has entries and mem is selected;
  - clears when alu is selected or the ALU FIFO is empty;
  - never exceeds STARVE_MAX.
- pending = either FIFO has entries. The sequencer must not toggle the read-side context flag for a mode switch while pending=1.
- q_hit is combinational over all valid entries in both FIFOs. It does not include same-cycle incoming requests. q_rd == 14 always returns 0.
- Ordering: writes from one requester to the same register commit in order. Between requesters, order follows arbitration only. Issue logic must stall on q_hit to avoid cross-path WAW and RAW hazards.

## Timing
- Reset (async assert, released synchronously by the clock domain):
  - both FIFOs empty, starve_cnt=0, drop_cnt=0;
  - rf_write=0, rf_rd=0, rf_data=0, rf_ucode=0;
  - pending=0, q_hit=0, alu_ready=1, mem_ready=1.
- Reset mid-operation discards all queued writes. None reach the register file.
- Latency: accepted on edge N → rf_write high in cycle N..N+1 (if selected) → committed at edge N+1. Minimum 1 cycle, no bypass from input to rf_*.
- Throughput: one write per cycle. Sustained pushes from both paths fill the FIFOs, and ready then drops on the losing path.
- Simultaneous pop and push on a non-full FIFO: count is unchanged, and the new entry sits behind the remaining ones.
- Pointer wrap-around uses DEPTH-sized pointers plus one extra bit for full/empty.

## Test plan
- Reset: assert rst mid-cycle with 2 ALU entries queued → outputs go to reset values immediately. After release, rf_write stays 0 with no further input.
- Single write: alu push rd=3, data=0xDEADBEEF, ucode=0 at edge 0 → rf_write=1, rf_rd=3, rf_data=0xDEADBEEF in cycle 0–1. pending=0 after edge 1.
- Priority and starvation: ALU and mem both valid every cycle, STARVE_MAX=3 → commit order mem, mem, mem, alu, mem, mem, mem, alu…
- R14 drop: push alu rd=14 and mem rd=14 in the same cycle → no rf_write, drop_cnt=2. 300 further R14 pushes → drop_cnt=255.
- Backpressure: mem valid every cycle, with the ALU FIFO filled to DEPTH=2 while mem holds the port → alu_ready=0. The ALU entries drain in order once selected, and alu_ready=1 again the cycle after the first pop.
- Hazard and context: queue mem rd=5 with ucode=1 → q_hit=1 for (5,1), q_hit=0 for (5,0). Commit has rf_ucode=1. q_hit=0 after the commit edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two register-file write requesters (ALU result
// path, memory-load return path), the register-file write port, and the
// hazard/status signals used by the issue logic.
//   alu_* / mem_*  : valid/ready request channels carrying {rd, data, ucode}
//   rf_*           : register-file write port (enable, destination, data, context)
//   pending        : any write still queued
//   q_rd, q_ucode  : hazard query; q_hit reports a queued match
//   drop_cnt       : saturating count of discarded R14 writes
// slave modport is taken by the arbiter, master by whatever drives it.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [3:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ucode;

    logic              mem_valid;
    logic              mem_ready;
    logic [3:0]        mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ucode;

    logic              rf_write;
    logic [3:0]        rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              rf_ucode;

    logic              pending;
    logic [3:0]        q_rd;
    logic              q_ucode;
    logic              q_hit;
    logic [7:0]        drop_cnt;

    modport slave (
        input  alu_valid, alu_rd, alu_data, alu_ucode,
        input  mem_valid, mem_rd, mem_data, mem_ucode,
        input  q_rd, q_ucode,
        output alu_ready, mem_ready,
        output rf_write, rf_rd, rf_data, rf_ucode,
        output pending, q_hit, drop_cnt
    );

    modport master (
        output alu_valid, alu_rd, alu_data, alu_ucode,
        output mem_valid, mem_rd, mem_data, mem_ucode,
        output q_rd, q_ucode,
        input  alu_ready, mem_ready,
        input  rf_write, rf_rd, rf_data, rf_ucode,
        input  pending, q_hit, drop_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 16x32 register file. Owns the single write port
// and shares it between the ALU path (requester 0) and the memory-load path
// (requester 1), each buffered by a DEPTH-entry FIFO. Memory has fixed
// priority; after STARVE_MAX consecutive ALU losses the ALU is forced to win.
// Writes to the hard-wired zero register R14 are discarded and counted.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_wb_arbiter_if.slave (request channels, rf write port,
//          pending, hazard query, drop counter)
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input logic               clk,
    input logic               rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam logic [3:0] ZERO_REG = 4'd14;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    // Index 0 = ALU, index 1 = memory load path.
    logic [1:0]        in_valid;
    logic [3:0]        in_rd    [2];
    logic [DATA_W-1:0] in_data  [2];
    logic              in_ucode [2];

    logic [3:0]        f_rd     [2][DEPTH];
    logic [DATA_W-1:0] f_data   [2][DEPTH];
    logic              f_ucode  [2][DEPTH];
    logic [PW-1:0]     wr_ptr   [2];
    logic [PW-1:0]     rd_ptr   [2];
    logic [PW-1:0]     count    [2];

    logic [1:0]        empty;
    logic [1:0]        full;
    logic [1:0]        take;
    logic [1:0]        drop;
    logic [1:0]        push;
    logic [1:0]        sel;
    logic [1:0]        hit;
    logic [AW-1:0]     idx;

    logic [SW-1:0]     starve_cnt;
    logic [7:0]        drop_q;
    logic [8:0]        drop_sum;

    logic              rf_write;
    logic [3:0]        rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              rf_ucode;

    assign in_valid = {bus.mem_valid, bus.alu_valid};
    assign in_rd    = '{bus.alu_rd, bus.mem_rd};
    assign in_data  = '{bus.alu_data, bus.mem_data};
    assign in_ucode = '{bus.alu_ucode, bus.mem_ucode};

    // FIFO status, push qualification and hazard search.
    always_comb begin
        count = '{default: '0};
        empty = '0;
        full  = '0;
        take  = '0;
        drop  = '0;
        push  = '0;
        hit   = '0;
        idx   = '0;
        for (int unsigned r = 0; r < 2; r++) begin
            count[r] = wr_ptr[r] - rd_ptr[r];
            empty[r] = (count[r] == '0);
            full[r]  = (count[r] == PW'(DEPTH));
            // Readiness ignores a same-cycle pop: a full FIFO never accepts.
            take[r]  = in_valid[r] && !full[r];
            drop[r]  = take[r] && (in_rd[r] == ZERO_REG);
            push[r]  = take[r] && (in_rd[r] != ZERO_REG);
            for (int unsigned k = 0; k < DEPTH; k++) begin
                idx = rd_ptr[r][AW-1:0] + AW'(k);
                if ((PW'(k) < count[r]) && (f_rd[r][idx] == bus.q_rd) &&
                    (f_ucode[r][idx] == bus.q_ucode)) begin
                    hit[r] = 1'b1;
                end
            end
        end
    end

    // Memory wins ties unless the ALU has lost STARVE_MAX times in a row.
    always_comb begin
        sel      = '0;
        rf_write = 1'b0;
        rf_rd    = '0;
        rf_data  = '0;
        rf_ucode = 1'b0;
        sel[0]   = !empty[0] && (empty[1] || (starve_cnt == STARVE_LIM));
        sel[1]   = !empty[1] && !sel[0];
        if (sel[0]) begin
            rf_write = 1'b1;
            rf_rd    = f_rd[0][rd_ptr[0][AW-1:0]];
            rf_data  = f_data[0][rd_ptr[0][AW-1:0]];
            rf_ucode = f_ucode[0][rd_ptr[0][AW-1:0]];
        end else if (sel[1]) begin
            rf_write = 1'b1;
            rf_rd    = f_rd[1][rd_ptr[1][AW-1:0]];
            rf_data  = f_data[1][rd_ptr[1][AW-1:0]];
            rf_ucode = f_ucode[1][rd_ptr[1][AW-1:0]];
        end
    end

    // Both requesters can drop R14 in one cycle; 255+2 still fits in 9 bits.
    always_comb begin
        drop_sum = {1'b0, drop_q} + 9'(drop[0]) + 9'(drop[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < 2; r++) begin
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
            end
            starve_cnt <= '0;
            drop_q     <= '0;
        end else begin
            for (int unsigned r = 0; r < 2; r++) begin
                if (push[r]) begin
                    wr_ptr[r] <= wr_ptr[r] + PW'(1);
                end
                if (sel[r]) begin
                    rd_ptr[r] <= rd_ptr[r] + PW'(1);
                end
            end
            if (empty[0] || sel[0]) begin
                starve_cnt <= '0;
            end else if (sel[1] && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Storage needs no reset: validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < 2; r++) begin
            if (push[r]) begin
                f_rd[r][wr_ptr[r][AW-1:0]]    <= in_rd[r];
                f_data[r][wr_ptr[r][AW-1:0]]  <= in_data[r];
                f_ucode[r][wr_ptr[r][AW-1:0]] <= in_ucode[r];
            end
        end
    end

    assign bus.alu_ready = !full[0];
    assign bus.mem_ready = !full[1];
    assign bus.rf_write  = rf_write;
    assign bus.rf_rd     = rf_rd;
    assign bus.rf_data   = rf_data;
    assign bus.rf_ucode  = rf_ucode;
    assign bus.pending   = !(empty[0] && empty[1]);
    assign bus.q_hit     = (bus.q_rd != ZERO_REG) && (hit != 2'b00);
    assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DATA_W=32, DEPTH=2, STARVE_MAX=3).
// Inputs change and outputs are checked on the falling edge; the DUT updates
// on the rising edge.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    regfile_wb_arbiter_if #(.DATA_W(32)) bus ();

    regfile_wb_arbiter #(
        .DATA_W     (32),
        .DEPTH      (2),
        .STARVE_MAX (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = 4'd0; bus.alu_data = '0; bus.alu_ucode = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_rd = 4'd0; bus.mem_data = '0; bus.mem_ucode = 1'b0;
        bus.q_rd = 4'd0; bus.q_ucode = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 20;
        while (bus.pending === 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        n_vec++;
        if (bus.pending !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_drain: got pending=%0b want 0", tag, bus.pending);
        end
    endtask

    task automatic test_reset();
        idle();
        bus.q_rd = 4'd3;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.rf_write !== 1'b0) begin n_bad++; $display("FAIL reset_rf_write: got %0b want 0", bus.rf_write); end
        n_vec++; if (bus.rf_rd !== 4'd0) begin n_bad++; $display("FAIL reset_rf_rd: got %0d want 0", bus.rf_rd); end
        n_vec++; if (bus.rf_data !== 32'd0) begin n_bad++; $display("FAIL reset_rf_data: got %h want 0", bus.rf_data); end
        n_vec++; if (bus.rf_ucode !== 1'b0) begin n_bad++; $display("FAIL reset_rf_ucode: got %0b want 0", bus.rf_ucode); end
        n_vec++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %0b want 0", bus.pending); end
        n_vec++; if (bus.q_hit !== 1'b0) begin n_bad++; $display("FAIL reset_q_hit: got %0b want 0", bus.q_hit); end
        n_vec++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_alu_ready: got %0b want 1", bus.alu_ready); end
        n_vec++; if (bus.mem_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mem_ready: got %0b want 1", bus.mem_ready); end
        n_vec++; if (bus.drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
        rst = 1'b0;
        tick();
        n_vec++; if (bus.rf_write !== 1'b0) begin n_bad++; $display("FAIL reset_idle_write: got %0b want 0", bus.rf_write); end

        // Queue two ALU entries behind a memory write, then reset mid-cycle.
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_data = 32'hA1A1_A1A1;
        bus.mem_valid = 1'b1; bus.mem_rd = 4'd2; bus.mem_data = 32'hB1B1_B1B1;
        tick();
        bus.mem_valid = 1'b0;
        bus.alu_data  = 32'hA2A2_A2A2;
        n_vec++; if (bus.rf_rd !== 4'd2) begin n_bad++; $display("FAIL reset_pre_mem_first: got rd=%0d want 2", bus.rf_rd); end
        tick();
        bus.alu_valid = 1'b0;
        n_vec++; if (bus.rf_data !== 32'hA1A1_A1A1) begin n_bad++; $display("FAIL reset_pre_alu_head: got %h want a1a1a1a1", bus.rf_data); end
        n_vec++; if (bus.alu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_pre_alu_full: got %0b want 0", bus.alu_ready); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.rf_write !== 1'b0) begin n_bad++; $display("FAIL reset_mid_rf_write: got %0b want 0", bus.rf_write); end
        n_vec++; if (bus.rf_data !== 32'd0) begin n_bad++; $display("FAIL reset_mid_rf_data: got %h want 0", bus.rf_data); end
        n_vec++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL reset_mid_pending: got %0b want 0", bus.pending); end
        n_vec++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_alu_ready: got %0b want 1", bus.alu_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.rf_write !== 1'b0) begin n_bad++; $display("FAIL reset_after_write[%0d]: got %0b want 0", i, bus.rf_write); end
        end
    endtask

    task automatic test_single_write();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_data = 32'hDEAD_BEEF; bus.alu_ucode = 1'b0;
        #1;
        n_vec++; if (bus.rf_write !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass: got %0b want 0", bus.rf_write); end
        tick();
        idle();
        n_vec++; if (bus.rf_write !== 1'b1) begin n_bad++; $display("FAIL single_rf_write: got %0b want 1", bus.rf_write); end
        n_vec++; if (bus.rf_rd !== 4'd3) begin n_bad++; $display("FAIL single_rf_rd: got %0d want 3", bus.rf_rd); end
        n_vec++; if (bus.rf_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rf_data: got %h want deadbeef", bus.rf_data); end
        n_vec++; if (bus.rf_ucode !== 1'b0) begin n_bad++; $display("FAIL single_rf_ucode: got %0b want 0", bus.rf_ucode); end
        tick();
        n_vec++; if (bus.rf_write !== 1'b0) begin n_bad++; $display("FAIL single_done_write: got %0b want 0", bus.rf_write); end
        n_vec++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL single_done_pending: got %0b want 0", bus.pending); end
    endtask

    task automatic test_priority();
        int  ai, mi, ac, mc;
        bit  acc_a, acc_m, want_alu;
        idle();
        ai = 0; mi = 0; ac = 0; mc = 0;
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd1;
        bus.mem_valid = 1'b1; bus.mem_rd = 4'd2;
        for (int t = 0; t <= 16; t++) begin
            bus.alu_data = 32'hA000_0000 + 32'(ai);
            bus.mem_data = 32'hB000_0000 + 32'(mi);
            if (t == 0) begin
                n_vec++; if (bus.rf_write !== 1'b0) begin n_bad++; $display("FAIL prio_first_write: got %0b want 0", bus.rf_write); end
            end else begin
                want_alu = ((t - 1) % 4) == 3;
                n_vec++; if (bus.rf_write !== 1'b1) begin n_bad++; $display("FAIL prio_write[%0d]: got %0b want 1", t, bus.rf_write); end
                if (want_alu) begin
                    n_vec++; if (bus.rf_rd !== 4'd1 || bus.rf_data !== 32'hA000_0000 + 32'(ac)) begin
                        n_bad++; $display("FAIL prio_alu[%0d]: got rd=%0d data=%h want rd=1 data=%h", t, bus.rf_rd, bus.rf_data, 32'hA000_0000 + 32'(ac));
                    end
                    ac++;
                end else begin
                    n_vec++; if (bus.rf_rd !== 4'd2 || bus.rf_data !== 32'hB000_0000 + 32'(mc)) begin
                        n_bad++; $display("FAIL prio_mem[%0d]: got rd=%0d data=%h want rd=2 data=%h", t, bus.rf_rd, bus.rf_data, 32'hB000_0000 + 32'(mc));
                    end
                    mc++;
                end
            end
            acc_a = bus.alu_ready;
            acc_m = bus.mem_ready;
            tick();
            if (acc_a) ai++;
            if (acc_m) mi++;
        end
        idle();
        drain("prio");
    endtask

    task automatic test_r14_drop();
        idle();
        n_vec++; if (bus.drop_cnt !== 8'd0) begin n_bad++; $display("FAIL r14_start: got %0d want 0", bus.drop_cnt); end
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd14; bus.alu_data = 32'h1111_1111;
        bus.mem_valid = 1'b1; bus.mem_rd = 4'd14; bus.mem_data = 32'h2222_2222; bus.mem_ucode = 1'b1;
        tick();
        n_vec++; if (bus.drop_cnt !== 8'd2) begin n_bad++; $display("FAIL r14_pair: got %0d want 2", bus.drop_cnt); end
        n_vec++; if (bus.rf_write !== 1'b0) begin n_bad++; $display("FAIL r14_no_write: got %0b want 0", bus.rf_write); end
        n_vec++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL r14_no_pending: got %0b want 0", bus.pending); end
        repeat (50) tick();
        n_vec++; if (bus.drop_cnt !== 8'd102) begin n_bad++; $display("FAIL r14_mid: got %0d want 102", bus.drop_cnt); end
        repeat (100) tick();
        idle();
        n_vec++; if (bus.drop_cnt !== 8'd255) begin n_bad++; $display("FAIL r14_saturate: got %0d want 255", bus.drop_cnt); end
        tick();
        n_vec++; if (bus.drop_cnt !== 8'd255) begin n_bad++; $display("FAIL r14_hold: got %0d want 255", bus.drop_cnt); end
    endtask

    task automatic test_backpressure();
        logic [3:0]  exp_rd [8] = '{4'd8, 4'd8, 4'd8, 4'd7, 4'd8, 4'd8, 4'd8, 4'd7};
        logic        exp_ar [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] alu_exp [2] = '{32'h1111_1111, 32'h2222_2222};
        int  mi, mc, ac;
        bit  acc_m;
        idle();
        mi = 0; mc = 0; ac = 0;
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 32'h1111_1111;
        bus.mem_valid = 1'b1; bus.mem_rd = 4'd8; bus.mem_data = 32'hC000_0000;
        mi = 1;
        tick();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) bus.alu_data = 32'h2222_2222;
            if (c == 1) bus.alu_valid = 1'b0;
            bus.mem_data = 32'hC000_0000 + 32'(mi);
            n_vec++; if (bus.alu_ready !== exp_ar[c]) begin n_bad++; $display("FAIL bp_alu_ready[%0d]: got %0b want %0b", c, bus.alu_ready, exp_ar[c]); end
            n_vec++; if (bus.rf_write !== 1'b1 || bus.rf_rd !== exp_rd[c]) begin
                n_bad++; $display("FAIL bp_rd[%0d]: got write=%0b rd=%0d want write=1 rd=%0d", c, bus.rf_write, bus.rf_rd, exp_rd[c]);
            end
            if (exp_rd[c] == 4'd7) begin
                n_vec++; if (bus.rf_data !== alu_exp[ac]) begin n_bad++; $display("FAIL bp_alu_data[%0d]: got %h want %h", c, bus.rf_data, alu_exp[ac]); end
                ac++;
            end else begin
                n_vec++; if (bus.rf_data !== 32'hC000_0000 + 32'(mc)) begin n_bad++; $display("FAIL bp_mem_data[%0d]: got %h want %h", c, bus.rf_data, 32'hC000_0000 + 32'(mc)); end
                mc++;
            end
            if (c == 1) begin
                bus.q_rd = 4'd7; bus.q_ucode = 1'b0; #1;
                n_vec++; if (bus.q_hit !== 1'b1) begin n_bad++; $display("FAIL bp_q_hit_7_0: got %0b want 1", bus.q_hit); end
                bus.q_ucode = 1'b1; #1;
                n_vec++; if (bus.q_hit !== 1'b0) begin n_bad++; $display("FAIL bp_q_hit_7_1: got %0b want 0", bus.q_hit); end
            end
            acc_m = bus.mem_ready;
            tick();
            if (acc_m) mi++;
        end
        bus.q_rd = 4'd7; bus.q_ucode = 1'b0; #1;
        n_vec++; if (bus.q_hit !== 1'b0) begin n_bad++; $display("FAIL bp_q_hit_after: got %0b want 0", bus.q_hit); end
        n_vec++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL bp_alu_ready_end: got %0b want 1", bus.alu_ready); end
        idle();
        drain("bp");
    endtask

    task automatic test_hazard();
        idle();
        bus.mem_valid = 1'b1; bus.mem_rd = 4'd5; bus.mem_data = 32'h5555_0005; bus.mem_ucode = 1'b1;
        bus.q_rd = 4'd5; bus.q_ucode = 1'b1; #1;
        n_vec++; if (bus.q_hit !== 1'b0) begin n_bad++; $display("FAIL haz_incoming: got %0b want 0", bus.q_hit); end
        tick();
        bus.mem_valid = 1'b0;
        #1;
        n_vec++; if (bus.q_hit !== 1'b1) begin n_bad++; $display("FAIL haz_hit_5_1: got %0b want 1", bus.q_hit); end
        bus.q_ucode = 1'b0; #1;
        n_vec++; if (bus.q_hit !== 1'b0) begin n_bad++; $display("FAIL haz_hit_5_0: got %0b want 0", bus.q_hit); end
        bus.q_rd = 4'd6; bus.q_ucode = 1'b1; #1;
        n_vec++; if (bus.q_hit !== 1'b0) begin n_bad++; $display("FAIL haz_hit_6_1: got %0b want 0", bus.q_hit); end
        n_vec++; if (bus.rf_write !== 1'b1 || bus.rf_rd !== 4'd5 || bus.rf_ucode !== 1'b1) begin
            n_bad++; $display("FAIL haz_commit: got write=%0b rd=%0d ucode=%0b want 1 5 1", bus.rf_write, bus.rf_rd, bus.rf_ucode);
        end
        bus.q_rd = 4'd5;
        tick();
        #1;
        n_vec++; if (bus.q_hit !== 1'b0) begin n_bad++; $display("FAIL haz_after_commit: got %0b want 0", bus.q_hit); end
        n_vec++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL haz_pending: got %0b want 0", bus.pending); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_write();
        test_priority();
        test_r14_drop();
        test_backpressure();
        test_hazard();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
